lin_rom_inverse_search: RTL and testbench
=========================================

Name: lin_rom_inverse_search

Overview:
- Sequential reverse-lookup engine for the 128-entry x 36-bit linearisation ROM.
- Takes a target word plus a compare mask and sweeps the full ROM address space through an external combinational ROM port.
- Reports the first matching address, a hit flag and the total match count over a valid/ready response channel.
- Sits beside the ROM as its reader and inverse: the ROM maps address to data; this block maps data back to address.

Parameters:
- ADDR_W, 7, ROM address width; the sweep covers 2^ADDR_W entries.
- DATA_W, 36, ROM data width and key/mask width.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- req_valid  in  1  Search request valid.
- req_ready  out  1  Block can accept a request.
- req_key  in  DATA_W  Target data word.
- req_mask  in  DATA_W  Compare mask; 1 = bit participates.
- rom_en  out  1  Address on rom_addr is a live scan address.
- rom_addr  out  ADDR_W  Registered ROM address.
- rom_data  in  DATA_W  Combinational ROM output for the current rom_addr.
- rsp_valid  out  1  Result valid.
- rsp_ready  in  1  Consumer accepts result.
- rsp_hit  out  1  At least one entry matched.
- rsp_addr  out  ADDR_W  Lowest matching address; 0 if no hit.
- rsp_count  out  ADDR_W+1  Number of matching entries, 0..2^ADDR_W.

Behaviour:
- Reset (async assert, sync deassert internally acceptable): state IDLE; req_ready=1; rom_en=0; rom_addr=0; rsp_valid=0; rsp_hit=0; rsp_addr=0; rsp_count=0; pipeline valid cleared.
- FSM states: IDLE, SCAN, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch key and mask; clear hit, addr and count accumulators; rom_addr<=0; rom_en<=1; go to SCAN.
- SCAN:
  - Each cycle: compare stage registers m = (((rom_data ^ key) & mask) == 0), tagged with rom_addr, with stage_valid=1.
  - If rom_addr == 2^ADDR_W-1: rom_en<=0, rom_addr holds, go to DRAIN. Otherwise rom_addr<=rom_addr+1.
- Accumulate stage (one cycle behind compare), when stage_valid & m:
  - count<=count+1.
  - If !hit: hit<=1 and addr<=tag. First hit wins.
- DRAIN: one cycle to accumulate the last entry; then go to RESP with rsp_* loaded from the accumulators.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid<=0, go to IDLE.
- Handshake rules:
  - req_ready is 1 only in IDLE, so no new request can be accepted in the cycle a response is taken. The earliest next accept is the following cycle.
  - req_key and req_mask are ignored outside the accept cycle.
- Latency: request accepted at edge T -> rom_addr sweeps 0..127 in cycles T+1..T+128 -> rsp_valid high from cycle T+130 (130 cycles fixed, ADDR_W=7).
- Arithmetic: rsp_count is 8 bits so that 128 is representable without wrap. rom_addr must not wrap past 127 during a scan.
- Boundary cases:
  - mask=0: every entry matches; count=128, addr=0, hit=1.
  - No match: hit=0, addr=0, count=0.
  - Match only at the last entry (127): captured via the DRAIN cycle.
- Reset mid-operation: scan aborts with no response; all outputs return to reset values immediately.

Test Plan (bench ROM model returns {29'h0, addr[6:0]}):
- key=36'h5, mask=36'hF_FFFF_FFFF -> rsp_hit=1, rsp_addr=5, rsp_count=1, rsp_valid first high exactly 130 cycles after accept.
- key=0, mask=0 -> rsp_hit=1, rsp_addr=0, rsp_count=128 (8'h80).
- key=36'h1, mask=36'h1 -> rsp_hit=1, rsp_addr=1, rsp_count=64; key=36'h7F, mask=36'hF_FFFF_FFFF -> addr=127, count=1 (last-entry DRAIN path).
- key=36'h800, mask=36'hF_FFFF_FFFF -> rsp_hit=0, rsp_addr=0, rsp_count=0.
- rsp_ready held 0 for 10 cycles -> rsp_* stable, req_ready=0 throughout. Release rsp_ready with req_valid already high -> new request accepted the cycle after the response handshake, not the same cycle.
- rst_n pulsed low when rom_addr=50 -> outputs at reset values immediately (rom_en=0, rom_addr=0, rsp_valid=0, req_ready=1). No response appears. A fresh request afterwards completes correctly.

Source files
------------

// File: rtl/lin_rom_inverse_search.sv
// Reverse lookup over the linearisation ROM: sweeps every address, compares masked data
// against a key, and returns the lowest matching address, a hit flag and the match count.
module lin_rom_inverse_search #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_key,
    input  logic [DATA_W-1:0] req_mask,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [ADDR_W:0]   rsp_count,
    output logic [1:0]        dbg_state
);

    // Both channels are valid/ready: a transfer happens on a rising edge where valid and
    // ready are both high; the responder holds rsp_* stable until that edge.
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESP} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t state, state_n;

    logic [DATA_W-1:0] key_q, mask_q;
    logic              stage_valid, stage_m;
    logic [ADDR_W-1:0] stage_tag;
    logic              acc_hit, acc_hit_n;
    logic [ADDR_W-1:0] acc_addr, acc_addr_n;
    logic [ADDR_W:0]   acc_count, acc_count_n;
    logic              accept;
    logic              match;

    assign accept    = (state == IDLE) && req_valid;
    assign match     = ((rom_data ^ key_q) & mask_q) == '0;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = SCAN;
            end
            SCAN:  if (rom_addr == LAST_ADDR) state_n = DRAIN;
            DRAIN: state_n = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Accumulator next values; DRAIN loads the response from these so the last entry counts.
    always_comb begin
        acc_hit_n   = acc_hit;
        acc_addr_n  = acc_addr;
        acc_count_n = acc_count;
        if (stage_valid && stage_m) begin
            acc_count_n = acc_count + (ADDR_W+1)'(1);
            if (!acc_hit) begin
                acc_hit_n  = 1'b1;
                acc_addr_n = stage_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q       <= '0;
            mask_q      <= '0;
            rom_en      <= 1'b0;
            rom_addr    <= '0;
            stage_valid <= 1'b0;
            stage_m     <= 1'b0;
            stage_tag   <= '0;
            acc_hit     <= 1'b0;
            acc_addr    <= '0;
            acc_count   <= '0;
            rsp_hit     <= 1'b0;
            rsp_addr    <= '0;
            rsp_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    stage_valid <= 1'b0;
                    if (accept) begin
                        key_q     <= req_key;
                        mask_q    <= req_mask;
                        acc_hit   <= 1'b0;
                        acc_addr  <= '0;
                        acc_count <= '0;
                        rom_addr  <= '0;
                        rom_en    <= 1'b1;
                    end
                end
                SCAN: begin
                    stage_valid <= 1'b1;
                    stage_m     <= match;
                    stage_tag   <= rom_addr;
                    acc_hit     <= acc_hit_n;
                    acc_addr    <= acc_addr_n;
                    acc_count   <= acc_count_n;
                    if (rom_addr == LAST_ADDR) rom_en <= 1'b0;
                    else                       rom_addr <= rom_addr + ADDR_W'(1);
                end
                DRAIN: begin
                    stage_valid <= 1'b0;
                    acc_hit     <= acc_hit_n;
                    acc_addr    <= acc_addr_n;
                    acc_count   <= acc_count_n;
                    rsp_hit     <= acc_hit_n;
                    rsp_addr    <= acc_addr_n;
                    rsp_count   <= acc_count_n;
                end
                default: stage_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_lin_rom_inverse_search.sv
// Bench for lin_rom_inverse_search: directed vector table, handshake/reset sequences and
// randomized ROM contents checked against a whole-ROM search model.
module tb_lin_rom_inverse_search;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 36;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] ALL = '1;
    localparam int EXP_LAT = 130;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready;
    logic [DATA_W-1:0] req_key, req_mask;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              rsp_valid, rsp_ready, rsp_hit;
    logic [ADDR_W-1:0] rsp_addr;
    logic [ADDR_W:0]   rsp_count;
    logic [1:0]        dbg_state;

    logic [DATA_W-1:0] rom_mem [DEPTH];
    assign rom_data = rom_mem[rom_addr];

    lin_rom_inverse_search #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_mask(req_mask),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_addr(rsp_addr), .rsp_count(rsp_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [DATA_W-1:0] key;
        logic [DATA_W-1:0] mask;
        logic              hit;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W:0]   count;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: scan every entry, count masked matches, remember the lowest one.
    function automatic logic [15:0] model(input logic [DATA_W-1:0] key, input logic [DATA_W-1:0] mask);
        int cnt = 0;
        int first = -1;
        for (int a = 0; a < DEPTH; a++) begin
            if (((rom_mem[a] ^ key) & mask) == '0) begin
                cnt++;
                if (first < 0) first = a;
            end
        end
        return {(first >= 0), (first >= 0) ? 7'(first) : 7'd0, 8'(cnt)};
    endfunction

    task automatic start_req(input logic [DATA_W-1:0] key, input logic [DATA_W-1:0] mask);
        int waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("req_ready before request", req_ready, 1);
        req_valid = 1'b1;
        req_key   = key;
        req_mask  = mask;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_key   = DATA_W'({$urandom(), $urandom()});
        req_mask  = DATA_W'({$urandom(), $urandom()});
    endtask

    // Called one step after the accept edge, i.e. in cycle 1 of the accept-relative count.
    task automatic wait_rsp(output int lat);
        int cyc = 1;
        while (!rsp_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        lat = cyc;
        check("rsp_valid arrives", rsp_valid, 1);
    endtask

    task automatic check_rsp(input string name);
        logic [15:0] exp;
        exp = exp_q.pop_front();
        check(name, {rsp_hit, rsp_addr, rsp_count}, exp);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid drops after handshake", rsp_valid, 0);
    endtask

    task automatic run_search(input string name, input logic [DATA_W-1:0] key,
                              input logic [DATA_W-1:0] mask, input logic [15:0] exp);
        int lat;
        exp_q.push_back(exp);
        start_req(key, mask);
        wait_rsp(lat);
        check({name, " latency"}, lat, EXP_LAT);
        check_rsp({name, " result"});
        finish_rsp();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        logic [DATA_W-1:0] rk, rm;

        vecs[0] = '{36'h5,   ALL,    1'b1, 7'd5,   8'd1};
        vecs[1] = '{36'h0,   36'h0,  1'b1, 7'd0,   8'd128};
        vecs[2] = '{36'h1,   36'h1,  1'b1, 7'd1,   8'd64};
        vecs[3] = '{36'h7F,  ALL,    1'b1, 7'd127, 8'd1};
        vecs[4] = '{36'h800, ALL,    1'b0, 7'd0,   8'd0};

        for (int a = 0; a < DEPTH; a++) rom_mem[a] = DATA_W'(a);

        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_key = '0; req_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        check("reset req_ready", req_ready, 1);
        check("reset rom_en", rom_en, 0);
        check("reset rom_addr", rom_addr, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp fields", {rsp_hit, rsp_addr, rsp_count}, 0);

        for (int i = 0; i < 5; i++)
            run_search($sformatf("vec%0d", i), vecs[i].key, vecs[i].mask,
                       {vecs[i].hit, vecs[i].addr, vecs[i].count});

        // Backpressure: response must hold, and no accept in the handshake cycle.
        exp_q.push_back({1'b1, 7'd5, 8'd1});
        start_req(36'h5, ALL);
        wait_rsp(lat);
        check("hold latency", lat, EXP_LAT);
        for (int i = 0; i < 10; i++) begin
            check("hold rsp_valid", rsp_valid, 1);
            check("hold req_ready", req_ready, 0);
            check("hold rsp fields", {rsp_hit, rsp_addr, rsp_count}, exp_q[0]);
            @(posedge clk); #1;
        end
        check_rsp("hold result");
        req_valid = 1'b1; req_key = 36'h10; req_mask = ALL; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("handshake rsp_valid", rsp_valid, 0);
        check("no same-cycle accept", rom_en, 0);
        check("req_ready after handshake", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("next-cycle accept rom_en", rom_en, 1);
        check("next-cycle accept rom_addr", rom_addr, 0);
        check("next-cycle accept req_ready", req_ready, 0);
        exp_q.push_back({1'b1, 7'd16, 8'd1});
        wait_rsp(lat);
        check("back-to-back latency", lat, EXP_LAT);
        check_rsp("back-to-back result");
        finish_rsp();

        // Reset in the middle of a scan.
        start_req(36'h7F, ALL);
        seen = 0;
        while (rom_addr != 7'd50 && seen < 100) begin
            @(posedge clk); #1;
            seen++;
        end
        check("scan reaches addr 50", rom_addr, 50);
        rst_n = 1'b0;
        #1;
        check("mid reset rom_en", rom_en, 0);
        check("mid reset rom_addr", rom_addr, 0);
        check("mid reset rsp_valid", rsp_valid, 0);
        check("mid reset req_ready", req_ready, 1);
        check("mid reset rsp fields", {rsp_hit, rsp_addr, rsp_count}, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        for (int i = 0; i < 140; i++) begin
            if (rsp_valid || rom_en) seen++;
            @(posedge clk); #1;
        end
        check("no activity after reset", seen, 0);
        run_search("post-reset", 36'h7F, ALL, model(36'h7F, ALL));

        // Randomized ROM contents with several matches per search.
        for (int a = 0; a < DEPTH; a++)
            rom_mem[a] = {DATA_W'($urandom_range(0, 3)) << 32} | DATA_W'($urandom_range(0, 15));
        for (int t = 0; t < 8; t++) begin
            rk = DATA_W'($urandom_range(0, 15)) | (DATA_W'($urandom_range(0, 3)) << 32);
            case ($urandom_range(0, 3))
                0:       rm = ALL;
                1:       rm = 36'h0_0000_0007;
                2:       rm = 36'h3_0000_0001;
                default: rm = DATA_W'({$urandom(), $urandom()});
            endcase
            run_search($sformatf("rand%0d", t), rk, rm, model(rk, rm));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
